// File: rtl/ise_pkg.sv
// Shared constants for the ISE host-side stream driver: geometry, word layout,
// FSM state encodings and result formatting.
package ise_pkg;

  localparam int IMAGE_NUM  = 32;
  localparam int IMAGE_SIZE = 128;
  localparam int TOTAL      = IMAGE_NUM * IMAGE_SIZE * IMAGE_SIZE;

  localparam int WORD_W  = 29;
  localparam int IDX_MSB = 28;
  localparam int IDX_LSB = 24;
  localparam int RGB_MSB = 23;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [2:0] RES_PAD = 3'b000;

endpackage

// File: rtl/ise_stream_driver_if.sv
// Pixel/result link between the host-side driver (master) and the ISE core (slave).
interface ise_stream_driver_if;
  // Pixel handshake: a word moves on a rising edge with pix_valid==1 and busy==0;
  // while busy==1 the master holds image_in_index/pixel_in stable. busy is the
  // inverse of ready. out_valid is a one-cycle result strobe with no back-pressure.
  logic [4:0]  image_in_index;
  logic [23:0] pixel_in;
  logic        pix_valid;
  logic        busy;
  logic        out_valid;
  logic [1:0]  color_index;
  logic [4:0]  image_out_index;

  modport master (
    output image_in_index, pixel_in, pix_valid,
    input  busy, out_valid, color_index, image_out_index
  );

  modport slave (
    input  image_in_index, pixel_in, pix_valid,
    output busy, out_valid, color_index, image_out_index
  );
endinterface

// File: rtl/ise_prefetch_fifo.sv
// Two-entry show-ahead FIFO holding prefetched source words; head is visible
// combinationally and push/pop in the same edge leave the count unchanged.
module ise_prefetch_fifo
  import ise_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              push,
  input  logic [WORD_W-1:0] wdata,
  input  logic              pop,
  output logic [WORD_W-1:0] rdata,
  output logic [1:0]        count
);

  logic [WORD_W-1:0] mem [2];
  logic              wp;
  logic              rp;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) wp <= ~wp;
      if (pop)  rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign rdata = mem[rp];

endmodule

// File: rtl/ise_stream_driver.sv
// Host-end ISE driver: prefetches packed pixel words from a synchronous memory,
// streams them under busy back-pressure and logs ISE results to a result memory.
module ise_stream_driver
  import ise_pkg::*;
#(
  parameter int IMAGE_NUM  = ise_pkg::IMAGE_NUM,
  parameter int IMAGE_SIZE = ise_pkg::IMAGE_SIZE,
  parameter int AW         = 19
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 mem_rd,
  output logic [AW-1:0]        mem_addr,
  input  logic [WORD_W-1:0]    mem_rdata,
  ise_stream_driver_if.master  ise,
  output logic                 res_we,
  output logic [4:0]           res_addr,
  output logic [9:0]           res_data,
  output logic [AW:0]          sent_cnt,
  output logic                 done,
  output logic                 ovf,
  output logic [2:0]           dbg_state
);

  localparam int         TOTAL   = IMAGE_NUM * IMAGE_SIZE * IMAGE_SIZE;
  localparam logic [AW:0] TOTAL_C = (AW+1)'(TOTAL);
  localparam logic [5:0]  NUM_C   = 6'(IMAGE_NUM);

  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic [AW:0]       addr_q;
  logic              rd_q;
  logic [WORD_W-1:0] fifo_head;
  logic [1:0]        fifo_cnt;
  logic              load;
  logic              xfer;
  logic              start_ok;
  logic [5:0]        res_cnt;

  assign start_ok  = start && (state == S_IDLE || state == S_DONE);
  assign xfer      = ise.pix_valid && !ise.busy;
  assign load      = (fifo_cnt != 2'd0) && (!ise.pix_valid || !ise.busy);
  assign mem_addr  = addr_q[AW-1:0];
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  // A word leaving the FIFO this edge frees a slot, so it may be refilled now.
  always_comb begin
    mem_rd = 1'b0;
    if ((state == S_FETCH || state == S_STREAM) && addr_q < TOTAL_C &&
        (({1'b0, fifo_cnt} + {2'b00, rd_q}) < (3'd2 + {2'b00, load})))
      mem_rd = 1'b1;
  end

  ise_prefetch_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (start_ok),
    .push  (rd_q),
    .wdata (mem_rdata),
    .pop   (load),
    .rdata (fifo_head),
    .count (fifo_cnt)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start_ok) state_nx = S_FETCH;
      S_FETCH:  if (mem_rd) state_nx = S_STREAM;
      S_STREAM: if (xfer && sent_cnt == TOTAL_C - (AW+1)'(1)) state_nx = S_DRAIN;
      S_DRAIN:  if (res_cnt == NUM_C) state_nx = S_DONE;
      S_DONE:   if (start_ok) state_nx = S_FETCH;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state              <= S_IDLE;
      addr_q             <= '0;
      rd_q               <= 1'b0;
      sent_cnt           <= '0;
      res_cnt            <= '0;
      res_we             <= 1'b0;
      res_addr           <= '0;
      res_data           <= '0;
      ovf                <= 1'b0;
      ise.pix_valid      <= 1'b0;
      ise.image_in_index <= '0;
      ise.pixel_in       <= '0;
    end else begin
      state <= state_nx;
      rd_q  <= mem_rd;

      if (start_ok) begin
        addr_q   <= '0;
        sent_cnt <= '0;
        res_cnt  <= '0;
        ovf      <= 1'b0;
      end else begin
        if (mem_rd) addr_q <= addr_q + (AW+1)'(1);
        if (xfer && sent_cnt != TOTAL_C) sent_cnt <= sent_cnt + (AW+1)'(1);
      end

      if (load) begin
        ise.pix_valid      <= 1'b1;
        ise.image_in_index <= fifo_head[IDX_MSB:IDX_LSB];
        ise.pixel_in       <= fifo_head[RGB_MSB:0];
      end else if (xfer) begin
        ise.pix_valid      <= 1'b0;
        ise.image_in_index <= '0;
        ise.pixel_in       <= '0;
      end

      // ISE may answer before streaming ends, so capture in every active state.
      res_we <= 1'b0;
      if (state != S_IDLE && ise.out_valid && !start_ok) begin
        if (res_cnt < NUM_C) begin
          res_we   <= 1'b1;
          res_addr <= res_cnt[4:0];
          res_data <= {ise.color_index, RES_PAD, ise.image_out_index};
          res_cnt  <= res_cnt + 6'd1;
        end else begin
          ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ise_stream_driver.sv
// Directed bench for ise_stream_driver with IMAGE_NUM=2, IMAGE_SIZE=2 (8 words).
module tb_ise_stream_driver;

  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [28:0]   mem_rdata = '0;
  logic          res_we;
  logic [4:0]    res_addr;
  logic [9:0]    res_data;
  logic [AW:0]   sent_cnt;
  logic          done;
  logic          ovf;
  logic [2:0]    dbg_state;

  ise_stream_driver_if ise_bus ();

  ise_stream_driver #(.IMAGE_NUM(2), .IMAGE_SIZE(2), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .ise       (ise_bus),
    .res_we    (res_we),
    .res_addr  (res_addr),
    .res_data  (res_data),
    .sent_cnt  (sent_cnt),
    .done      (done),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic mon_en = 1'b0;
  logic [28:0] exp_q[$];

  function automatic logic [28:0] word(int k);
    logic [23:0] base;
    base = 24'hA00000;
    return {5'(k), base + 24'(k)};
  endfunction

  // synchronous source memory: data one cycle after the read strobe
  always @(posedge clk) if (mem_rd) mem_rdata <= word(int'(mem_addr));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_mem_rd"}, 32'(mem_rd), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_pix_valid"}, 32'(ise_bus.pix_valid), 0);
    chk({tag, "_index"}, 32'(ise_bus.image_in_index), 0);
    chk({tag, "_pixel"}, 32'(ise_bus.pixel_in), 0);
    chk({tag, "_sent"}, 32'(sent_cnt), 0);
    chk({tag, "_res_we"}, 32'(res_we), 0);
    chk({tag, "_res_addr"}, 32'(res_addr), 0);
    chk({tag, "_res_data"}, 32'(res_data), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ovf"}, 32'(ovf), 0);
    chk({tag, "_state"}, 32'(dbg_state), 0);
  endtask

  task automatic fill_exp();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(word(i));
  endtask

  // scoreboard: every accepted word must match memory order
  always @(negedge clk) begin
    logic [28:0] got;
    if (mon_en && ise_bus.pix_valid && !ise_bus.busy) begin
      got = {ise_bus.image_in_index, ise_bus.pixel_in};
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stream_extra: got %0h expected none", got);
      end else begin
        chk("stream_order", 32'(got), 32'(exp_q.pop_front()));
      end
    end
  end

  typedef struct {
    logic        start;
    logic        ov;
    logic [1:0]  col;
    logic [4:0]  oidx;
    logic        e_rd;
    logic [18:0] e_addr;
    logic        e_pv;
    logic [4:0]  e_idx;
    logic [23:0] e_pix;
    logic [19:0] e_sent;
    logic        e_we;
    logic [4:0]  e_raddr;
    logic [9:0]  e_rdata;
    logic        e_done;
    logic        e_ovf;
  } vec_t;

  vec_t tv[15];

  initial begin
    bit hit;
    reset = 1'b0;
    start = 1'b0;
    ise_bus.busy = 1'b0;
    ise_bus.out_valid = 1'b0;
    ise_bus.color_index = '0;
    ise_bus.image_out_index = '0;

    // rows: k = cycles after the edge that sampled start; inputs applied in cycle k
    for (int k = 0; k < 15; k++) begin
      tv[k] = '{default: '0};
      tv[k].e_rd   = (k < 8);
      tv[k].e_addr = (k < 8) ? 19'(k) : 19'd8;
      tv[k].e_sent = (k <= 3) ? 20'd0 : (k <= 10) ? 20'(k - 3) : 20'd8;
      if (k >= 3 && k <= 10) begin
        tv[k].e_pv  = 1'b1;
        tv[k].e_idx = 5'(k - 3);
        tv[k].e_pix = 24'hA00000 + 24'(k - 3);
      end
    end
    tv[5].ov = 1'b1;  tv[5].col = 2'b10; tv[5].oidx = 5'd7;
    tv[6].e_we = 1'b1; tv[6].e_raddr = 5'd0; tv[6].e_rdata = 10'h207;
    tv[8].ov = 1'b1;  tv[8].col = 2'b01; tv[8].oidx = 5'd3;
    tv[9].e_we = 1'b1; tv[9].e_raddr = 5'd1; tv[9].e_rdata = 10'h103;
    tv[12].e_done = 1'b1;
    tv[12].ov = 1'b1; tv[12].col = 2'b11; tv[12].oidx = 5'd31;
    tv[13].e_done = 1'b1; tv[13].e_ovf = 1'b1;
    tv[13].start = 1'b1;
    tv[14].e_rd = 1'b1; tv[14].e_addr = 19'd0; tv[14].e_sent = 20'd0;

    step(); step(); step();
    chk_idle_outputs("reset");
    reset = 1'b1;
    step();

    // run 1: table-driven stream with results, overflow and restart
    start = 1'b1;
    step();
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("t%0d_mem_rd", k), 32'(mem_rd), 32'(tv[k].e_rd));
      chk($sformatf("t%0d_mem_addr", k), 32'(mem_addr), 32'(tv[k].e_addr));
      chk($sformatf("t%0d_pix_valid", k), 32'(ise_bus.pix_valid), 32'(tv[k].e_pv));
      chk($sformatf("t%0d_index", k), 32'(ise_bus.image_in_index), 32'(tv[k].e_idx));
      chk($sformatf("t%0d_pixel", k), 32'(ise_bus.pixel_in), 32'(tv[k].e_pix));
      chk($sformatf("t%0d_sent", k), 32'(sent_cnt), 32'(tv[k].e_sent));
      chk($sformatf("t%0d_res_we", k), 32'(res_we), 32'(tv[k].e_we));
      if (tv[k].e_we) begin
        chk($sformatf("t%0d_res_addr", k), 32'(res_addr), 32'(tv[k].e_raddr));
        chk($sformatf("t%0d_res_data", k), 32'(res_data), 32'(tv[k].e_rdata));
      end
      chk($sformatf("t%0d_done", k), 32'(done), 32'(tv[k].e_done));
      chk($sformatf("t%0d_ovf", k), 32'(ovf), 32'(tv[k].e_ovf));
      start = tv[k].start;
      ise_bus.out_valid = tv[k].ov;
      ise_bus.color_index = tv[k].col;
      ise_bus.image_out_index = tv[k].oidx;
      step();
    end
    start = 1'b0;

    // run 2 (restarted above): busy held for 5 cycles on word 3
    fill_exp();
    mon_en = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      if (ise_bus.pix_valid && ise_bus.image_in_index == 5'd3) hit = 1'b1;
    end
    if (!hit) fail_now("wait_word3");
    ise_bus.busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      chk("hold_valid", 32'(ise_bus.pix_valid), 1);
      chk("hold_index", 32'(ise_bus.image_in_index), 3);
      chk("hold_pixel", 32'(ise_bus.pixel_in), 32'h00A00003);
    end
    chk("hold_mem_rd_stopped", 32'(mem_rd), 0);
    ise_bus.busy = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      if (sent_cnt == 20'd8) hit = 1'b1;
    end
    if (!hit) fail_now("wait_sent8_hold");
    chk("hold_sent", 32'(sent_cnt), 8);
    chk("hold_all_seen", 32'(exp_q.size()), 0);
    chk("hold_not_done", 32'(done), 0);

    // back-to-back results finish the run
    ise_bus.out_valid = 1'b1;
    ise_bus.color_index = 2'b00;
    ise_bus.image_out_index = 5'd0;
    step();
    chk("b2b_we0", 32'(res_we), 1);
    chk("b2b_addr0", 32'(res_addr), 0);
    step();
    chk("b2b_we1", 32'(res_we), 1);
    chk("b2b_addr1", 32'(res_addr), 1);
    ise_bus.out_valid = 1'b0;
    step();
    chk("b2b_done", 32'(done), 1);
    chk("b2b_ovf", 32'(ovf), 0);

    // run 3: busy toggling every cycle
    fill_exp();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("tog_restart_done", 32'(done), 0);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      ise_bus.busy = ~ise_bus.busy;
      step();
      if (sent_cnt == 20'd8) hit = 1'b1;
    end
    if (!hit) fail_now("wait_sent8_toggle");
    ise_bus.busy = 1'b0;
    step(); step();
    chk("tog_sent_sat", 32'(sent_cnt), 8);
    chk("tog_valid_low", 32'(ise_bus.pix_valid), 0);
    chk("tog_mem_rd", 32'(mem_rd), 0);
    chk("tog_all_seen", 32'(exp_q.size()), 0);
    mon_en = 1'b0;

    // run 4: start ignored mid-stream, then reset aborts the run
    reset = 1'b0;
    step();
    reset = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ign_start_addr", 32'(mem_addr), 5);
    chk("ign_start_state", 32'(dbg_state), 2);
    reset = 1'b0;
    step();
    chk_idle_outputs("abort");
    reset = 1'b1;
    fill_exp();
    mon_en = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("replay_mem_rd", 32'(mem_rd), 1);
    chk("replay_addr", 32'(mem_addr), 0);
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      step();
      if (sent_cnt == 20'd8) hit = 1'b1;
    end
    if (!hit) fail_now("wait_sent8_replay");
    step();
    chk("replay_all_seen", 32'(exp_q.size()), 0);
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
